// File: rtl/ram_dma.sv
// ram_dma: byte-copy DMA engine driving a single-port RAM with combinational read data.
// Define RAM_DMA_FILL_EN to add a constant-fill mode (fill_i / fill_value_i).
module ram_dma #(
  parameter int Bits = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            abort_i,
`ifdef RAM_DMA_FILL_EN
  input  logic            fill_i,
  input  logic [7:0]      fill_value_i,
`endif
  input  logic [Bits-1:0] src_addr_i,
  input  logic [Bits-1:0] dst_addr_i,
  input  logic [Bits-1:0] length_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [Bits-1:0] mem_addr_o,
  output logic [7:0]      mem_wdata_o,
  input  logic [7:0]      mem_rdata_i,
  output logic            mem_we_o
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t          state_q;
  logic [Bits-1:0] src_q, dst_q, cnt_q, addr_q;
  logic [Bits-1:0] src_d, dst_d, cnt_d;
  logic [7:0]      hold_q;
  logic            busy_q, done_q, we_q;
`ifdef RAM_DMA_FILL_EN
  logic fill_q, fill_start;
  assign fill_start = fill_i;
`else
  localparam logic fill_q = 1'b0;
  localparam logic fill_start = 1'b0;
`endif
  always_comb begin
    src_d = src_q + 1'b1;
    dst_d = dst_q + 1'b1;
    cnt_d = cnt_q - 1'b1;
  end
  // hold_q doubles as the write-data register: read byte in copy mode, fill byte in fill mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
`ifdef RAM_DMA_FILL_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          src_q <= src_addr_i;
          dst_q <= dst_addr_i;
          cnt_q <= length_i;
`ifdef RAM_DMA_FILL_EN
          fill_q <= fill_i;
          if (fill_i) hold_q <= fill_value_i;
`endif
          if (length_i == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= fill_start ? WRITE : READ;
            addr_q  <= fill_start ? dst_addr_i : src_addr_i;
            we_q    <= fill_start;
            busy_q  <= 1'b1;
          end
        end
        READ: if (abort_i) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else begin
          hold_q  <= mem_rdata_i;
          state_q <= WRITE;
          addr_q  <= dst_q;
          we_q    <= 1'b1;
        end
        WRITE: begin
          src_q <= src_d;
          dst_q <= dst_d;
          cnt_q <= cnt_d;
          if (abort_i || cnt_q == Bits'(1)) begin
            state_q <= abort_i ? IDLE : DONE;
            done_q  <= !abort_i;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
          end else begin
            state_q <= fill_q ? WRITE : READ;
            addr_q  <= fill_q ? dst_d : src_d;
            we_q    <= fill_q;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = hold_q;
  assign mem_we_o    = we_q;
endmodule

// File: doc/ram_dma.md
RAM_DMA -- requirements
Module: ram_dma

Interface
REQ-001 Parameter: Bits, default 16, address width and length width (64 KB space).
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous reset, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 abort  input  1  terminates an active transfer.
REQ-006 srcAddress  input  Bits  first source byte address.
REQ-007 dstAddress  input  Bits  first destination byte address.
REQ-008 length  input  Bits  byte count; 0 means zero bytes.
REQ-009 busy  output  1  high while a transfer is active.
REQ-010 done  output  1  one-cycle pulse on normal completion.
REQ-011 memAddress  output  Bits  address to RAM.
REQ-012 memWriteData  output  8  write data to RAM.
REQ-013 memReadData  input  8  combinational read data from RAM at memAddress.
REQ-014 memWriteEnabled  output  1  RAM write strobe; the write takes effect on the posedge where it is high.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, READ, WRITE and DONE.
REQ-016 In IDLE, start=1 SHALL latch srcAddress, dstAddress and length into internal pointers and a remaining-count register.
REQ-017 On that edge, the FSM SHALL go to READ if length != 0, else to DONE.
REQ-018 In IDLE, memWriteEnabled SHALL be 0 and memAddress SHALL hold its last value.
REQ-019 In READ: memAddress = source pointer, memWriteEnabled = 0.
REQ-020 At the end of READ, memReadData SHALL be captured into an 8-bit hold register, and the FSM SHALL go to WRITE.
REQ-021 In WRITE: memAddress = destination pointer, memWriteData = hold, memWriteEnabled = 1.
REQ-022 At the end of WRITE, both pointers SHALL increment by 1 and the remaining count SHALL decrement by 1.
REQ-023 After WRITE, the FSM SHALL go to DONE if the remaining count was 1, else to READ.
REQ-024 In DONE, done = 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-025 busy SHALL be 1 in READ and WRITE, and 0 in IDLE and DONE.
REQ-026 Latency: start accepted at edge N -> done high during cycle N+2*length+1; copy throughput is 2 cycles per byte.
REQ-027 Pointers SHALL wrap modulo 2^Bits (0xFFFF + 1 -> 0x0000); wrap is not an error.
REQ-028 Bytes SHALL be copied in ascending order; for overlapping regions, the result is exactly that of a forward byte-by-byte copy.
REQ-029 start SHALL be ignored outside IDLE, including start held high during DONE.
REQ-030 abort=1 in READ SHALL return the FSM to IDLE with no write.
REQ-031 abort=1 in WRITE SHALL let that cycle's write complete, then return to IDLE.
REQ-032 An aborted transfer SHALL produce no done pulse; abort in IDLE or DONE has no effect.

Reset
REQ-033 reset=0 SHALL immediately force: state IDLE, busy=0, done=0, memWriteEnabled=0, memAddress=0, memWriteData=0, pointers, count and hold all 0.
REQ-034 Reset asserted mid-transfer SHALL drop memWriteEnabled combinationally with no partial write; no transfer resumes after reset release.

Configuration
REQ-035 Macro RAM_DMA_FILL_EN: when defined, the inputs fill (1) and fillValue (8) SHALL exist, and fill SHALL be latched with start.
REQ-036 With RAM_DMA_FILL_EN defined and fill latched as 1, READ SHALL be skipped: every cycle is WRITE with memWriteData = fillValue (latched at start).
REQ-037 A fill transfer SHALL run at 1 cycle per byte, with done during cycle N+length+1.
REQ-038 With RAM_DMA_FILL_EN undefined, the fill ports SHALL be absent and only copy is supported.

Verification
REQ-039 RAM preloaded 0x10..0x13 = AA,BB,CC,DD; src=0x0010, dst=0x0200, len=4 -> 0x0200..0x0203 = AA,BB,CC,DD; done 9 cycles after start edge; busy high 8 cycles.
REQ-040 len=0 -> no memWriteEnabled; done pulses in the cycle after start; busy stays 0.
REQ-041 src=0xFFFE, dst=0x0100, len=4 -> bytes from 0xFFFE,0xFFFF,0x0000,0x0001 land at 0x0100..0x0103.
REQ-042 Overlap: 0x20=11, 0x21=22; src=0x20, dst=0x21, len=2 -> 0x21=11, 0x22=11.
REQ-043 len=8, abort during the 3rd WRITE -> exactly 3 bytes written, no done, IDLE next cycle; reset low mid-READ -> all outputs 0 immediately.
REQ-044 RAM_DMA_FILL_EN defined: fill=1, fillValue=0x5A, dst=0x0300, len=3 -> 0x0300..0x0302 = 5A; done 4 cycles after start.
